bin2bcd_seq: RTL
================

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 Parameter BIN_W, default 7, binary input width; legal range 1..9.
REQ-002 Parameter DIGITS, default 3, number of BCD output digits; DIGITS*4 = BCD_W.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 start  input  1  request a conversion of bin; sampled on clk rising edge.
REQ-006 bin  input  BIN_W  unsigned binary operand; sampled only when start is accepted.
REQ-007 busy  output  1  high while a conversion is in progress.
REQ-008 done  output  1  single-cycle pulse; marks a new result on bcd.
REQ-009 bcd  output  BCD_W  packed BCD result, most significant digit in the top nibble (hundreds[11:8], tens[7:4], ones[3:0] at default).

Function
REQ-010 The block SHALL convert bin to BCD with the shift-and-add-3 (double-dabble) algorithm: one iteration per clock.
- Each iteration: every BCD nibble >= 5 gets +3, then the whole {bcd_scratch, bin_shift} register shifts left by 1.
REQ-011 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-012 IDLE with start=1 SHALL do all of the following in one edge:
- load bin_shift = bin;
- clear bcd_scratch;
- load the iteration counter = BIN_W;
- go to SHIFT.
REQ-013 SHIFT SHALL perform one iteration per cycle and decrement the counter.
- When the counter reaches 0 on an edge, that edge SHALL copy the final scratch to bcd and go to DONE.
REQ-014 DONE SHALL last exactly one cycle, with done=1.
- start=1 in DONE is accepted exactly as in IDLE: the next edge goes to SHIFT.
- Otherwise the next edge returns to IDLE.
REQ-015 Latency:
- start high in cycle N (IDLE or DONE) -> busy=1 in cycles N+1..N+BIN_W;
- done=1 and the new bcd are valid in cycle N+BIN_W+1;
- busy=0 in that cycle.
REQ-016 Throughput SHALL be one conversion per BIN_W+1 cycles with start held high continuously.
REQ-017 start while busy=1 SHALL be ignored, with no effect on the conversion in flight or on bin sampling.
REQ-018 bin changing after acceptance SHALL NOT affect the result.
REQ-019 bcd SHALL hold the last result unchanged until the next DONE edge; it is never updated with partial values.
REQ-020 busy and done SHALL be registered outputs and SHALL never both be high.
REQ-021 Range: every value 0..2^BIN_W-1 SHALL convert exactly.
- At default width the maximum is 127 -> 0x127.
- Unused upper digits SHALL read 0.

Reset
REQ-022 rst=1 at a clock edge SHALL force all of the following, with priority over start and over any state:
- state=IDLE;
- busy=0, done=0, bcd=0;
- counter and scratch registers cleared.
REQ-023 Reset mid-conversion SHALL abort the conversion with no done pulse.
- start on the first cycle after rst deasserts SHALL be accepted normally.

Structure
REQ-024 A shared package bin2bcd_pkg SHALL hold:
- the state enum (IDLE, SHIFT, DONE);
- the default BIN_W and DIGITS constants;
- the derived BCD_W and counter-width constants.
REQ-025 The per-nibble "add 3 if >= 5" adjust SHALL be a combinational sub-module bcd_add3 (4-bit in, 4-bit out), instantiated DIGITS times.
REQ-026 The top level SHALL contain only the FSM, the counter, the shift register and the output registers.
- Target size: 120-250 lines.

Verification
REQ-027 Basic conversion: rst for 2 cycles, then start=1 for one cycle with bin=42.
- done=1 exactly 8 cycles later with bcd=0x042; busy=1 for the 7 preceding cycles.
REQ-028 Boundaries:
- bin=0 -> bcd=0x000;
- bin=127 -> bcd=0x127;
- bin=13 -> bcd=0x013;
- an exhaustive sweep of 0..127 checks each result against a reference model.
REQ-029 Busy collision: start bin=99, then start=1 with bin=5 during cycle N+3.
- Single done at N+8 with bcd=0x099; no second done.
REQ-030 Back-to-back: start held high, bin=66 then bin=100 presented at the DONE cycle.
- done at N+8 with 0x066, then at N+16 with 0x100.
REQ-031 Reset mid-op: start bin=88, then rst=1 in cycle N+4.
- No done pulse; bcd=0x000 and busy=0 from the cycle after the reset edge.
- The following start with bin=21 yields 0x021 after 8 cycles.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Defaults describe the 7-bit / 3-digit configuration.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int BIN_W_DEF  = 7;
  localparam int DIGITS_DEF = 3;
  localparam int BCD_W_DEF  = DIGITS_DEF * 4;

  // Counter must hold BIN_W itself, not just BIN_W-1.
  function automatic int cnt_width(input int bin_w);
    return $clog2(bin_w + 1);
  endfunction

  localparam int CNT_W_DEF = cnt_width(BIN_W_DEF);

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble adjust: add 3 to a BCD digit that is 5 or more
// so the following left shift carries correctly into the next digit.
module bcd_add3 (
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  assign nib_o = (nib_i >= 4'd5) ? nib_i + 4'd3 : nib_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter using shift-and-add-3, one iteration
// per clock; result is published on bcd together with a one-cycle done pulse.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = BIN_W_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [DIGITS*4-1:0]   bcd
);

  localparam int BCD_W = DIGITS * 4;
  localparam int CNT_W = cnt_width(BIN_W);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   shift_q, shift_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [BCD_W-1:0]   adj;
  logic [BCD_W-1:0]   shifted;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_add3 u_add3 (
      .nib_i (scratch_q[g*4 +: 4]),
      .nib_o (adj[g*4 +: 4])
    );
  end

  // Adjusted digits shift left, pulling in the binary MSB.
  assign shifted = {adj[BCD_W-2:0], shift_q[BIN_W-1]};

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    bcd_d     = bcd_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          shift_d   = bin;
          scratch_d = '0;
          cnt_d     = CNT_W'(BIN_W);
          state_d   = SHIFT;
        end else begin
          state_d   = IDLE;
        end
      end
      SHIFT: begin
        scratch_d = shifted;
        shift_d   = shift_q << 1;
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          bcd_d   = shifted;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      scratch_q <= '0;
      bcd_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      bcd_q     <= bcd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule
